decode_scoreboard: RTL and testbench

Issue controller for the decode stage: tracks which architectural registers have an in-flight write, and gates issue of each decoded instruction until its sources and destination are free. Sits between the decode stage (register file read plus immediate generator) and execute. Its `pending` state qualifies `data1`/`data2` as valid. It drains the pipeline on flush.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/sb_hazard_check.sv | 43 ++++
 rtl/decode_scoreboard.sv | 113 +++++++++++
 tb/tb_decode_scoreboard.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// =============================================================================
// rv_pkg : shared register-address, scoreboard-state and sizing definitions
// Revision: 1.0
// =============================================================================
`default_nettype none

package rv_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sb_state_t;

endpackage

`default_nettype wire

// File: rtl/sb_hazard_check.sv
// =============================================================================
// sb_hazard_check : source (RAW) and destination (WAW) compare against pending
// Optional macro DECODE_SCOREBOARD_WB_BYPASS_EN: a clearing writeback frees its
// register in the same cycle.
// Revision: 1.0
// =============================================================================
`default_nettype none

module sb_hazard_check
  import rv_pkg::*;
(
  input  logic [NUM_REGS-1:0] i_pending,
  input  reg_addr_t           i_rs1,
  input  reg_addr_t           i_rs2,
  input  reg_addr_t           i_rd,
  input  logic                i_use_rs1,
  input  logic                i_use_rs2,
  input  logic                i_wr,
`ifdef DECODE_SCOREBOARD_WB_BYPASS_EN
  input  logic                i_wclr,
  input  reg_addr_t           i_wb_rd,
`endif
  output logic                o_src_haz,
  output logic                o_dst_haz
);

  logic [NUM_REGS-1:0] w_busy;

  always_comb begin
    w_busy    = i_pending;
`ifdef DECODE_SCOREBOARD_WB_BYPASS_EN
    // Register file forwards the write, so the clearing register is readable now.
    if (i_wclr) w_busy[i_wb_rd] = 1'b0;
`endif
    w_busy[0] = 1'b0;
  end

  assign o_src_haz = (i_use_rs1 & w_busy[i_rs1]) | (i_use_rs2 & w_busy[i_rs2]);
  assign o_dst_haz = i_wr & w_busy[i_rd];

endmodule

`default_nettype wire

// File: rtl/decode_scoreboard.sv
// =============================================================================
// decode_scoreboard : decode-stage issue controller with pending-write scoreboard
// Optional macro DECODE_SCOREBOARD_WB_BYPASS_EN enables same-cycle writeback bypass.
// Revision: 1.0
// =============================================================================
`default_nettype none

module decode_scoreboard
  import rv_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 id_valid,
  input  logic [4:0]                           id_rs1,
  input  logic [4:0]                           id_rs2,
  input  logic [4:0]                           id_rd,
  input  logic                                 id_use_rs1,
  input  logic                                 id_use_rs2,
  input  logic                                 id_wr,
  output logic                                 id_ready,
  input  logic                                 wb_valid,
  input  logic [4:0]                           wb_rd,
  input  logic                                 flush,
  output logic                                 busy,
  output logic [31:0]                          pending,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
  output logic [STALL_CNT_W-1:0]               stall_cnt
);

  localparam int              IW             = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0]   c_MAX_INFLIGHT = IW'(MAX_INFLIGHT);

  sb_state_t                r_state;
  logic [NUM_REGS-1:0]      r_pending;
  logic [IW-1:0]            r_inflight;
  logic [STALL_CNT_W-1:0]   r_stall_cnt;

  logic                     w_wclr;
  logic                     w_src_haz;
  logic                     w_dst_haz;
  logic                     w_full;
  logic                     w_set;
  logic [NUM_REGS-1:0]      w_pending_nxt;
  logic [IW-1:0]            w_inflight_nxt;

  assign w_wclr = wb_valid & (wb_rd != 5'd0) & r_pending[wb_rd];

  sb_hazard_check u_hazard (
    .i_pending (r_pending),
    .i_rs1     (id_rs1),
    .i_rs2     (id_rs2),
    .i_rd      (id_rd),
    .i_use_rs1 (id_use_rs1),
    .i_use_rs2 (id_use_rs2),
    .i_wr      (id_wr),
`ifdef DECODE_SCOREBOARD_WB_BYPASS_EN
    .i_wclr    (w_wclr),
    .i_wb_rd   (wb_rd),
`endif
    .o_src_haz (w_src_haz),
    .o_dst_haz (w_dst_haz)
  );

  // A retiring writeback in the same cycle frees a slot for a new writer.
  assign w_full   = id_wr & (id_rd != 5'd0) & (r_inflight == c_MAX_INFLIGHT) & ~w_wclr;
  assign id_ready = (r_state == RUN) & ~flush & ~w_src_haz & ~w_dst_haz & ~w_full;
  assign w_set    = id_valid & id_ready & id_wr & (id_rd != 5'd0);

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wclr) w_pending_nxt[wb_rd] = 1'b0;
    if (w_set)  w_pending_nxt[id_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_set && !w_wclr && (r_inflight != c_MAX_INFLIGHT))
      w_inflight_nxt = r_inflight + IW'(1);
    else if (!w_set && w_wclr && (r_inflight != '0))
      w_inflight_nxt = r_inflight - IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_pending   <= '0;
      r_inflight  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_inflight <= w_inflight_nxt;
      if (id_valid && !id_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      case (r_state)
        RUN:     if (flush && (w_inflight_nxt != '0)) r_state <= DRAIN;
        DRAIN:   if (w_inflight_nxt == '0)            r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  assign busy      = (r_state == DRAIN);
  assign pending   = r_pending;
  assign inflight  = r_inflight;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
// =============================================================================
// tb_decode_scoreboard : vector table, directed corner sequences and random run
// against a scoreboard model; honours DECODE_SCOREBOARD_WB_BYPASS_EN.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_decode_scoreboard;

`ifdef DECODE_SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXI    = 4;
  localparam int SCW     = 5;
  localparam int SAT_MAX = (1 << SCW) - 1;

  logic             clk, rst_n;
  logic             id_valid, id_use_rs1, id_use_rs2, id_wr, id_ready;
  logic [4:0]       id_rs1, id_rs2, id_rd, wb_rd;
  logic             wb_valid, flush, busy;
  logic [31:0]      pending;
  logic [2:0]       inflight;
  logic [SCW-1:0]   stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  decode_scoreboard #(.MAX_INFLIGHT(MAXI), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr(id_wr),
    .id_ready(id_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy(busy),
    .pending(pending), .inflight(inflight), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                       input logic u1, input logic u2, input logic wr,
                       input logic wbv, input int wbr, input logic fl);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_use_rs1 = u1; id_use_rs2 = u2; id_wr = wr;
    wb_valid = wbv; wb_rd = 5'(wbr); flush = fl;
  endtask

  // ---------------- behavioural model: a set of outstanding registers ----------
  bit m_pend [32];
  bit m_drain;
  int m_stall;

  function automatic int m_count();
    int n = 0;
    for (int i = 1; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] p = '0;
    for (int i = 0; i < 32; i++) p[i] = m_pend[i];
    return p;
  endfunction

  function automatic bit m_busyreg(input int r, input bit wclr, input int wbr);
    return (r != 0) && m_pend[r] && !(BYP && wclr && (wbr == r));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_drain = 1'b0;
    m_stall = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b1, 5, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset_pending", pending, 32'h0);
    chk("reset_inflight", 32'(inflight), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_stall", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_issue", 32'(id_ready), 32'h1);
    m_reset();
  endtask

  typedef struct {
    logic v; logic [4:0] rs1, rs2, rd; logic u1, u2, wr, wbv; logic [4:0] wbr; logic fl;
    logic rdy; logic [2:0] infl; logic bsy; logic [31:0] pend;
  } vec_t;
  vec_t tbl [22];

  initial begin
    bit wclr, haz, full, rdy;
    int last;

    //          v  rs1 rs2 rd u1 u2 wr wbv wbr fl  rdy infl bsy pend
    tbl[0]  = '{1, 5,  0,  1, 1, 0, 1, 0,  0,  0,  1,  0,   0,  32'h0};
    tbl[1]  = '{1, 0,  0,  2, 0, 0, 1, 0,  0,  0,  1,  1,   0,  32'h2};
    tbl[2]  = '{1, 0,  0,  3, 0, 0, 1, 0,  0,  0,  1,  2,   0,  32'h6};
    tbl[3]  = '{1, 0,  0,  4, 0, 0, 1, 0,  0,  0,  1,  3,   0,  32'hE};
    tbl[4]  = '{1, 0,  0,  9, 0, 0, 1, 0,  0,  0,  0,  4,   0,  32'h1E};
    tbl[5]  = '{1, 10, 0,  9, 1, 0, 0, 0,  0,  0,  1,  4,   0,  32'h1E};
    tbl[6]  = '{1, 0,  0,  9, 0, 0, 1, 1,  1,  0,  1,  4,   0,  32'h1E};
    tbl[7]  = '{0, 0,  0,  0, 0, 0, 0, 1,  12, 0,  1,  4,   0,  32'h21C};
    tbl[8]  = '{0, 0,  0,  0, 0, 0, 0, 0,  0,  0,  1,  4,   0,  32'h21C};
    tbl[9]  = '{1, 0,  0,  2, 0, 0, 1, 0,  0,  0,  0,  4,   0,  32'h21C};
    tbl[10] = '{1, 0,  0,  0, 0, 0, 1, 0,  0,  0,  1,  4,   0,  32'h21C};
    tbl[11] = '{1, 0,  0,  0, 1, 1, 1, 0,  0,  0,  1,  4,   0,  32'h21C};
    tbl[12] = '{0, 0,  0,  0, 0, 0, 0, 1,  0,  0,  1,  4,   0,  32'h21C};
    tbl[13] = '{1, 0,  0,  0, 0, 0, 0, 0,  0,  1,  0,  4,   0,  32'h21C};
    tbl[14] = '{1, 0,  0,  0, 0, 0, 0, 1,  2,  0,  0,  4,   1,  32'h21C};
    tbl[15] = '{1, 0,  0,  0, 0, 0, 0, 1,  3,  1,  0,  3,   1,  32'h218};
    tbl[16] = '{0, 0,  0,  0, 0, 0, 0, 1,  4,  0,  0,  2,   1,  32'h210};
    tbl[17] = '{0, 0,  0,  0, 0, 0, 0, 1,  9,  0,  0,  1,   1,  32'h200};
    tbl[18] = '{1, 0,  0,  5, 0, 0, 1, 0,  0,  0,  1,  0,   0,  32'h0};
    tbl[19] = '{0, 0,  0,  0, 0, 0, 0, 1,  5,  0,  1,  1,   0,  32'h20};
    tbl[20] = '{1, 0,  0,  0, 0, 0, 0, 0,  0,  1,  0,  0,   0,  32'h0};
    tbl[21] = '{1, 0,  0,  6, 0, 0, 1, 0,  0,  0,  1,  0,   0,  32'h0};

    rst_n = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // ---- table: fill, WAW, x0, spurious writeback, flush/drain ----
    do_reset();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].v, int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].rd), tbl[i].u1,
            tbl[i].u2, tbl[i].wr, tbl[i].wbv, int'(tbl[i].wbr), tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(id_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_inflight", i), 32'(inflight), 32'(tbl[i].infl));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].pend);
    end

    // ---- RAW stall: writeback to x3 four cycles after the reader appears ----
    do_reset();
    @(negedge clk);
    drive(1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    #1 chk("raw_writer_issue", 32'(id_ready), 32'h1);
    last = BYP ? 5 : 6;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      drive(1'b1, 3, 0, 0, 1'b1, 1'b0, 1'b0, c == 5, 3, 1'b0);
      #1 chk($sformatf("raw_cycle%0d_ready", c), 32'(id_ready), 32'(c == last));
    end
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("raw_stall_cnt", 32'(stall_cnt), BYP ? 32'd4 : 32'd5);
    chk("raw_inflight", 32'(inflight), 32'h0);

    // ---- asynchronous reset mid-drain, then a stale writeback ----
    @(negedge clk);
    drive(1'b1, 0, 0, 8, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    drive(1'b1, 8, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #1 chk("drain_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_pending", pending, 32'h0);
    chk("async_rst_inflight", 32'(inflight), 32'h0);
    chk("async_rst_stall", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b0);
    #1 chk("stale_wb_ready", 32'(id_ready), 32'h1);
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #1 chk("stale_wb_inflight", 32'(inflight), 32'h0);

    // ---- randomized run against the set-based model ----
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 7), $urandom_range(0, 19) == 0);
      #1;
      wclr = wb_valid && (wb_rd != 0) && m_pend[wb_rd];
      haz  = (id_use_rs1 && m_busyreg(int'(id_rs1), wclr, int'(wb_rd))) ||
             (id_use_rs2 && m_busyreg(int'(id_rs2), wclr, int'(wb_rd))) ||
             (id_wr && m_busyreg(int'(id_rd), wclr, int'(wb_rd)));
      full = id_wr && (id_rd != 0) && (m_count() == MAXI) && !wclr;
      rdy  = !m_drain && !flush && !haz && !full;
      chk("rand_ready", 32'(id_ready), 32'(rdy));
      chk("rand_pending", pending, m_vec());
      chk("rand_inflight", 32'(inflight), 32'(m_count()));
      chk("rand_busy", 32'(busy), 32'(m_drain));
      chk("rand_stall", 32'(stall_cnt), 32'(m_stall));
      if (wclr) m_pend[wb_rd] = 1'b0;
      if (id_valid && rdy && id_wr && (id_rd != 0)) m_pend[id_rd] = 1'b1;
      if (id_valid && !rdy && (m_stall < SAT_MAX)) m_stall++;
      m_drain = m_drain ? (m_count() != 0) : (flush && (m_count() != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
